// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter (start, DATA_W-or-fewer data bits LSB
// first, optional parity, STOP_BITS stop bits). Each bit is held for a
// run-time period P sampled at accept time together with the word length N.
// Optional parity generation is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        data_size,
    input  logic [13:0]       bit_period,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic              parity_en,
    input  logic              parity_odd,
`endif
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    localparam logic [3:0] DATA_W4  = 4'(DATA_W);
    localparam logic       TWO_STOP = (STOP_BITS == 2);

    state_t              state_reg, state_next;
    logic [13:0]         timer_reg, timer_next;
    logic [13:0]         period_reg, period_next;
    logic [3:0]          nbits_reg, nbits_next;
    logic [3:0]          bit_cnt_reg, bit_cnt_next;
    logic                stop_cnt_reg, stop_cnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                tx_out_reg, tx_out_next;
    logic                tx_done_reg, tx_done_next;

    logic                accept;
    logic                bit_strobe;
    logic                last_stop;
    logic [3:0]          n_eff;
    logic [13:0]         p_eff;

    assign accept     = tx_valid && (state_reg == S_IDLE);
    assign bit_strobe = (timer_reg == period_reg);
    assign last_stop  = !TWO_STOP || stop_cnt_reg;

    // Out-of-range word lengths fall back to the full data width; a zero
    // period would never strobe, so it is treated as one cycle per bit.
    assign n_eff = ((data_size == 4'd0) || (data_size > DATA_W4)) ? DATA_W4 : data_size;
    assign p_eff = (bit_period == 14'd0) ? 14'd1 : bit_period;

`ifdef UART_TX_PARITY_EN
    logic              parity_on_reg, parity_on_next;
    logic              parity_bit_reg, parity_bit_next;
    logic [DATA_W-1:0] n_mask;

    // Mask selecting only the N bits that will actually go on the line.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
        assign n_mask[gi] = (4'(gi) < n_eff);
    end
`endif

    // State register plus the registered line outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            tx_out_reg  <= 1'b1;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tx_out_reg  <= tx_out_next;
            tx_done_reg <= tx_done_next;
        end
    end

    // Next-state logic: every bit-phase transition happens on the bit strobe.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_START;
            S_START:  if (bit_strobe) state_next = S_DATA;
            S_DATA: begin
                if (bit_strobe && (bit_cnt_reg == (nbits_reg - 4'd1))) begin
`ifdef UART_TX_PARITY_EN
                    state_next = parity_on_reg ? S_PARITY : S_STOP;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_strobe) state_next = S_STOP;
`endif
            S_STOP:   if (bit_strobe && last_stop) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic: line level is looked up from the state being entered so
    // that the registered tx_out changes in the same cycle as the state.
    always_comb begin
        tx_out_next  = 1'b1;
        tx_done_next = (state_reg == S_STOP) && (state_next == S_IDLE);
        case (state_next)
            S_IDLE:   tx_out_next = 1'b1;
            S_START:  tx_out_next = 1'b0;
            S_DATA:   tx_out_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_out_next = parity_bit_reg;
`endif
            S_STOP:   tx_out_next = 1'b1;
            default:  tx_out_next = 1'b1;
        endcase
    end

    // Datapath next values: frame config is captured once at accept so later
    // input changes cannot disturb a frame in flight.
    always_comb begin
        timer_next    = timer_reg;
        period_next   = period_reg;
        nbits_next    = nbits_reg;
        bit_cnt_next  = bit_cnt_reg;
        stop_cnt_next = stop_cnt_reg;
        shift_next    = shift_reg;
`ifdef UART_TX_PARITY_EN
        parity_on_next  = parity_on_reg;
        parity_bit_next = parity_bit_reg;
`endif
        if (state_reg == S_IDLE) begin
            timer_next = 14'd0;
            if (accept) begin
                timer_next    = 14'd1;
                period_next   = p_eff;
                nbits_next    = n_eff;
                bit_cnt_next  = 4'd0;
                stop_cnt_next = 1'b0;
                shift_next    = tx_data;
`ifdef UART_TX_PARITY_EN
                parity_on_next  = parity_en;
                parity_bit_next = (^(tx_data & n_mask)) ^ parity_odd;
`endif
            end
        end else begin
            timer_next = bit_strobe ? 14'd1 : timer_reg + 14'd1;
            if ((state_reg == S_DATA) && bit_strobe) begin
                shift_next   = shift_reg >> 1;
                bit_cnt_next = bit_cnt_reg + 4'd1;
            end
            if ((state_reg == S_STOP) && bit_strobe) begin
                stop_cnt_next = ~stop_cnt_reg;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_reg    <= 14'd0;
            period_reg   <= 14'd0;
            nbits_reg    <= 4'd0;
            bit_cnt_reg  <= 4'd0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_on_reg  <= 1'b0;
            parity_bit_reg <= 1'b0;
`endif
        end else begin
            timer_reg    <= timer_next;
            period_reg   <= period_next;
            nbits_reg    <= nbits_next;
            bit_cnt_reg  <= bit_cnt_next;
            stop_cnt_reg <= stop_cnt_next;
            shift_reg    <= shift_next;
`ifdef UART_TX_PARITY_EN
            parity_on_reg  <= parity_on_next;
            parity_bit_reg <= parity_bit_next;
`endif
        end
    end

    assign tx_ready = (state_reg == S_IDLE);
    assign tx_out   = tx_out_reg;
    assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Expected line waveforms are
// built from the frame rules as a list of bit values, each held P cycles.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        data_size;
    logic [13:0]       bit_period;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
`ifdef UART_TX_PARITY_EN
    logic              parity_en;
    logic              parity_odd;
`endif
    logic              tx_ready;
    logic              tx_out;
    logic              tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    bit exp_q[$];
    int exp_p;

    uart_tx #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_size  (data_size),
        .bit_period (bit_period),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
`ifdef UART_TX_PARITY_EN
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
`endif
        .tx_ready   (tx_ready),
        .tx_out     (tx_out),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Reference frame: list of line levels, one per serial bit.
    task automatic build_expected(input logic [DATA_W-1:0] d, input int ds, input int bp,
                                  input bit pen, input bit podd);
        int n;
        bit par;
        n     = (ds == 0 || ds > DATA_W) ? DATA_W : ds;
        exp_p = (bp == 0) ? 1 : bp;
        exp_q.delete();
        exp_q.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[i]);
            par = par ^ d[i];
        end
        if (pen) exp_q.push_back(par ^ podd);
        for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
    endtask

    // Present a word and wait (bounded) until it is accepted; returns at
    // 1ns after the accept edge, i.e. inside frame cycle 1.
    task automatic start_word(input logic [DATA_W-1:0] d, input int ds, input int bp,
                              input bit pen, input bit podd, input bit keep_valid);
        int waited;
        tx_data    = d;
        data_size  = 4'(ds);
        bit_period = 14'(bp);
`ifdef UART_TX_PARITY_EN
        parity_en  = pen;
        parity_odd = podd;
`endif
        tx_valid   = 1'b1;
        build_expected(d, ds, bp, pen, podd);
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, waited);
        end
        @(posedge clk); #1;
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Compare the line against the expected frame, then the tx_done cycle.
    task automatic capture_frame(input string name, input int inject_at, input bit check_after);
        int  len, first_bad, bad_rdy, bad_done;
        bit  eb, got_bad;
        logic got_bit;
        len = exp_q.size() * exp_p;
        first_bad = -1; bad_rdy = 0; bad_done = 0; got_bit = 1'b0; eb = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (tx_out !== exp_q[c / exp_p] && first_bad < 0) begin
                first_bad = c;
                got_bit   = tx_out;
                eb        = exp_q[c / exp_p];
            end
            if (tx_ready !== 1'b0) bad_rdy++;
            if (tx_done !== 1'b0) bad_done++;
            if (inject_at >= 0 && c == inject_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end else if (inject_at >= 0 && c == inject_at + 1) begin
                tx_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        got_bad = (first_bad >= 0);
        if (got_bad) begin
            n_bad++;
            $display("FAIL %s_line: frame cycle %0d tx_out=%b, required %b", name, first_bad + 1, got_bit, eb);
        end
        n_cmp++;
        if (bad_rdy != 0) begin
            n_bad++;
            $display("FAIL %s_ready_busy: tx_ready high in %0d frame cycles, required 0", name, bad_rdy);
        end
        n_cmp++;
        if (bad_done != 0) begin
            n_bad++;
            $display("FAIL %s_done_early: tx_done high in %0d frame cycles, required 0", name, bad_done);
        end
        n_cmp++;
        if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done_cycle: done=%b ready=%b out=%b, required 1 1 1", name, tx_done, tx_ready, tx_out);
        end
        if (check_after) begin
            @(posedge clk); #1;
            n_cmp++;
            if (tx_done !== 1'b0 || tx_out !== 1'b1) begin
                n_bad++;
                $display("FAIL %s_after: done=%b out=%b, required 0 1", name, tx_done, tx_out);
            end
        end
        $display("frame %s: %0d bits x P=%0d = %0d cycles, errors_in_frame=%0d", name,
                 exp_q.size(), exp_p, len, (got_bad ? 1 : 0) + (bad_rdy != 0 ? 1 : 0) + (bad_done != 0 ? 1 : 0));
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0; data_size = 4'd0; bit_period = 14'd0;
`ifdef UART_TX_PARITY_EN
        parity_en = 1'b0; parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_out !== 1'b1) begin n_bad++; $display("FAIL reset_out: tx_out=%b, required 1", tx_out); end
        n_cmp++;
        if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: tx_ready=%b, required 1", tx_ready); end
        n_cmp++;
        if (tx_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: tx_done=%b, required 0", tx_done); end
        rst = 1'b0;
        @(posedge clk); #1;
        $display("reset: out=%b ready=%b done=%b", tx_out, tx_ready, tx_done);
    endtask

    task automatic test_basic_frame();
        start_word(8'hA5, 8, 4, 1'b0, 1'b0, 1'b0);
        capture_frame("a5_n8_p4", -1, 1'b1);
    endtask

    task automatic test_short_word();
        start_word(8'hFF, 5, 3, 1'b0, 1'b0, 1'b0);
        capture_frame("ff_n5_p3", -1, 1'b1);
    endtask

    task automatic test_boundary();
        // data_size above DATA_W falls back to DATA_W; period 0 means 1
        start_word(8'h3B, 12, 0, 1'b0, 1'b0, 1'b0);
        capture_frame("3b_n12_p0", -1, 1'b1);
        start_word(8'hC6, 0, 1, 1'b0, 1'b0, 1'b0);
        capture_frame("c6_n0_p1", -1, 1'b1);
        start_word(8'h01, 1, 2, 1'b0, 1'b0, 1'b0);
        capture_frame("01_n1_p2", -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        start_word(8'h01, 8, 2, 1'b0, 1'b0, 1'b1);
        tx_data = 8'h80;
        capture_frame("b2b_first", -1, 1'b0);
        build_expected(8'h80, 8, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        capture_frame("b2b_second", -1, 1'b1);
    endtask

    task automatic test_ignore_busy();
        start_word(8'h55, 8, 3, 1'b0, 1'b0, 1'b0);
        capture_frame("55_busy_valid", 10, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (tx_ready !== 1'b1 || tx_out !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_ignored_idle: ready=%b out=%b, required 1 1", tx_ready, tx_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad_done, bad_out;
        start_word(8'hA3, 8, 4, 1'b0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_async: out=%b ready=%b, required 1 1", tx_out, tx_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bad_done = 0; bad_out = 0;
        for (int c = 0; c < 50; c++) begin
            if (tx_done !== 1'b0) bad_done++;
            if (tx_out !== 1'b1) bad_out++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad_done != 0 || bad_out != 0) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: done_cycles=%0d low_cycles=%0d, required 0 0", bad_done, bad_out);
        end
        $display("reset mid-frame: line idle after abandon");
        start_word(8'h0F, 8, 2, 1'b0, 1'b0, 1'b0);
        capture_frame("0f_after_reset", -1, 1'b1);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        int ds, bp;
        bit pen, podd;
        for (int k = 0; k < 12; k++) begin
            d  = DATA_W'($urandom);
            ds = $urandom_range(0, 15);
            bp = $urandom_range(0, 5);
`ifdef UART_TX_PARITY_EN
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
`else
            pen  = 1'b0;
            podd = 1'b0;
`endif
            start_word(d, ds, bp, pen, podd, 1'b0);
            // scramble config while the frame is in flight
            tx_data    = DATA_W'($urandom);
            data_size  = 4'($urandom);
            bit_period = 14'($urandom_range(0, 9));
`ifdef UART_TX_PARITY_EN
            parity_en  = ~pen;
            parity_odd = ~podd;
`endif
            capture_frame($sformatf("rand%0d_d%02h_n%0d_p%0d", k, d, ds, bp), -1, 1'b1);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        start_word(8'h07, 8, 2, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (exp_q.size() * exp_p != 22 || exp_q[9] != 1'b1) begin
            n_bad++;
            $display("FAIL parity_model: len=%0d, required 22", exp_q.size() * exp_p);
        end
        capture_frame("07_even_parity", -1, 1'b1);
        start_word(8'h07, 8, 2, 1'b1, 1'b1, 1'b0);
        capture_frame("07_odd_parity", -1, 1'b1);
        start_word(8'h07, 8, 2, 1'b0, 1'b1, 1'b0);
        capture_frame("07_parity_off", -1, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_short_word();
        test_boundary();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
